// File: rtl/mem2_arbiter.sv
// mem2_arbiter
//   Shares the bus-2 memory controller between two line-level requesters
//   (port 0 = data cache, port 1 = instruction cache). A round-robin pick in
//   IDLE selects one requester; the block then runs exactly one full line
//   transaction on the memory side. The transaction is either a write
//   (C2_WRITE_LINE plus LINE_BEATS data beats) or a read (C2_READ_LINE). In
//   both cases the block then waits for C2_RESPONSE, collects the read beats
//   for a read, and reports completion.
//
// Ports
//   CLK            clock, all state changes on posedge
//   RESET          synchronous active-low reset
//   REQ[1:0]       per-requester transaction request (level, sampled in IDLE)
//   WR[1:0]        per-requester direction: 1 = write line, 0 = read line
//   ADDR0/ADDR1    line address of requester 0/1
//   WDATA0/WDATA1  write beat of requester 0/1
//   GNT[1:0]       registered pulse: request of r has been latched
//   WR_BEAT[1:0]   combinational: WDATA of r consumed this cycle
//   RD_BEAT[1:0]   combinational: RDATA holds a read beat for r this cycle
//   RDATA          combinational: read beat forwarded from M_RDATA
//   DONE[1:0]      registered pulse: transaction of r completed
//   ERR[1:0]       registered pulse with DONE: transaction of r aborted
//   M_CMD          registered memory command (0 NOP, 2 READ_LINE, 3 WRITE_LINE)
//   M_ADDR         registered line address, valid in command cycles only
//   M_WDATA        combinational write beat, 0 outside write beats
//   M_RESP         memory response code, 1 = C2_RESPONSE
//   M_RDATA        memory read beat, valid while M_RESP == 1
module mem2_arbiter #(
    parameter int ADDR2_W    = 14,
    parameter int DATA2_W    = 16,
    parameter int LINE_BEATS = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [1:0]         REQ,
    input  logic [1:0]         WR,
    input  logic [ADDR2_W-1:0] ADDR0,
    input  logic [ADDR2_W-1:0] ADDR1,
    input  logic [DATA2_W-1:0] WDATA0,
    input  logic [DATA2_W-1:0] WDATA1,
    output logic [1:0]         GNT,
    output logic [1:0]         WR_BEAT,
    output logic [1:0]         RD_BEAT,
    output logic [DATA2_W-1:0] RDATA,
    output logic [1:0]         DONE,
    output logic [1:0]         ERR,
    output logic [1:0]         M_CMD,
    output logic [ADDR2_W-1:0] M_ADDR,
    output logic [DATA2_W-1:0] M_WDATA,
    input  logic [1:0]         M_RESP,
    input  logic [DATA2_W-1:0] M_RDATA
);

    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);
    // Abort is decided in the cycle whose count is TIMEOUT-1, so the
    // FINISH cycle lands exactly TIMEOUT+1 cycles after the read command.
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] C2_NOP        = 2'd0;
    localparam logic [1:0] C2_RESPONSE   = 2'd1;
    localparam logic [1:0] C2_READ_LINE  = 2'd2;
    localparam logic [1:0] C2_WRITE_LINE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_SEND   = 3'd1,
        S_RD_CMD    = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_RD_BEATS  = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                win_r;
    logic                wr_r;
    logic                ptr_r;
    logic                err_r;
    logic                err_s;
    logic [ADDR2_W-1:0]  addr_r;
    logic [BEAT_W-1:0]   beat_r;
    logic [BEAT_W-1:0]   beat_s;
    logic [TO_W-1:0]     to_r;
    logic [TO_W-1:0]     to_s;

    logic [1:0]          gnt_r;
    logic [1:0]          gnt_s;
    logic [1:0]          done_r;
    logic [1:0]          done_s;
    logic [1:0]          err_o_r;
    logic [1:0]          err_o_s;
    logic [1:0]          m_cmd_r;
    logic [1:0]          m_cmd_s;
    logic [ADDR2_W-1:0]  m_addr_r;
    logic [ADDR2_W-1:0]  m_addr_s;

    logic                req_any_s;
    logic                win_s;
    logic                resp_s;
    logic                rd_ok_s;
    logic [ADDR2_W-1:0]  addr_sel_s;

    // One-hot port select for a single requester index
    function automatic logic [1:0] port_sel(input logic p);
        return p ? 2'b10 : 2'b01;
    endfunction

    // Round-robin pick: the pointer port wins if it asks, else the other one
    assign req_any_s  = |REQ;
    assign win_s      = REQ[ptr_r] ? ptr_r : ~ptr_r;
    assign addr_sel_s = win_s ? ADDR1 : ADDR0;
    assign resp_s     = (M_RESP == C2_RESPONSE);

    // State register, transaction context and registered outputs
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_r  <= S_IDLE;
            win_r    <= 1'b0;
            wr_r     <= 1'b0;
            ptr_r    <= 1'b0;
            err_r    <= 1'b0;
            addr_r   <= {ADDR2_W{1'b0}};
            beat_r   <= {BEAT_W{1'b0}};
            to_r     <= {TO_W{1'b0}};
            gnt_r    <= 2'b00;
            done_r   <= 2'b00;
            err_o_r  <= 2'b00;
            m_cmd_r  <= C2_NOP;
            m_addr_r <= {ADDR2_W{1'b0}};
        end else begin
            state_r  <= state_s;
            err_r    <= err_s;
            beat_r   <= beat_s;
            to_r     <= to_s;
            gnt_r    <= gnt_s;
            done_r   <= done_s;
            err_o_r  <= err_o_s;
            m_cmd_r  <= m_cmd_s;
            m_addr_r <= m_addr_s;
            if (state_r == S_IDLE && req_any_s) begin
                win_r  <= win_s;
                wr_r   <= WR[win_s];
                addr_r <= addr_sel_s;
            end
            if (state_r == S_FINISH) begin
                ptr_r <= ~win_r;
            end
        end
    end

    // Next-state logic with beat / timeout counter updates
    always_comb begin
        state_s = state_r;
        beat_s  = beat_r;
        to_s    = to_r;
        err_s   = err_r;
        case (state_r)
            S_IDLE: begin
                beat_s = {BEAT_W{1'b0}};
                to_s   = {TO_W{1'b0}};
                err_s  = 1'b0;
                if (req_any_s) begin
                    if (WR[win_s]) begin
                        state_s = S_WR_SEND;
                    end else begin
                        state_s = S_RD_CMD;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WR_SEND: begin
                if (beat_r == LAST_BEAT) begin
                    state_s = S_WAIT_RESP;
                    beat_s  = {BEAT_W{1'b0}};
                end else begin
                    beat_s  = beat_r + BEAT_W'(1);
                end
            end
            S_RD_CMD: begin
                state_s = S_WAIT_RESP;
            end
            S_WAIT_RESP: begin
                // A read response cycle already carries beat 0
                if (resp_s) begin
                    if (wr_r || (LINE_BEATS == 1)) begin
                        state_s = S_FINISH;
                    end else begin
                        state_s = S_RD_BEATS;
                        beat_s  = BEAT_W'(1);
                    end
                end else if (to_r == TO_LAST) begin
                    state_s = S_FINISH;
                    err_s   = 1'b1;
                end else begin
                    to_s    = to_r + TO_W'(1);
                end
            end
            S_RD_BEATS: begin
                // A gap in the burst aborts; beats already forwarded stand
                if (!resp_s) begin
                    state_s = S_FINISH;
                    err_s   = 1'b1;
                end else if (beat_r == LAST_BEAT) begin
                    state_s = S_FINISH;
                end else begin
                    beat_s  = beat_r + BEAT_W'(1);
                end
            end
            S_FINISH: begin
                state_s = S_IDLE;
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Output decode: next values of registered outputs (aligned with the
    // state being entered) plus the combinational beat outputs
    always_comb begin
        gnt_s    = 2'b00;
        done_s   = 2'b00;
        err_o_s  = 2'b00;
        m_cmd_s  = C2_NOP;
        m_addr_s = {ADDR2_W{1'b0}};

        if (state_r == S_IDLE && req_any_s) begin
            gnt_s = port_sel(win_s);
        end else begin
            gnt_s = 2'b00;
        end

        case (state_s)
            S_WR_SEND: begin
                m_cmd_s  = C2_WRITE_LINE;
                m_addr_s = (state_r == S_IDLE) ? addr_sel_s : addr_r;
            end
            S_RD_CMD: begin
                m_cmd_s  = C2_READ_LINE;
                m_addr_s = addr_sel_s;
            end
            S_FINISH: begin
                done_s  = port_sel(win_r);
                err_o_s = err_s ? port_sel(win_r) : 2'b00;
            end
            default: begin
                m_cmd_s  = C2_NOP;
                m_addr_s = {ADDR2_W{1'b0}};
            end
        endcase

        rd_ok_s = resp_s && (((state_r == S_WAIT_RESP) && !wr_r) || (state_r == S_RD_BEATS));

        if (state_r == S_WR_SEND) begin
            WR_BEAT = port_sel(win_r);
            M_WDATA = win_r ? WDATA1 : WDATA0;
        end else begin
            WR_BEAT = 2'b00;
            M_WDATA = {DATA2_W{1'b0}};
        end

        if (rd_ok_s) begin
            RD_BEAT = port_sel(win_r);
            RDATA   = M_RDATA;
        end else begin
            RD_BEAT = 2'b00;
            RDATA   = {DATA2_W{1'b0}};
        end
    end

    assign GNT    = gnt_r;
    assign DONE   = done_r;
    assign ERR    = err_o_r;
    assign M_CMD  = m_cmd_r;
    assign M_ADDR = m_addr_r;

endmodule

// File: tb/tb_mem2_arbiter.sv
// Self-checking bench for mem2_arbiter: a cycle-by-cycle vector table for a
// short write and a short read, plus hand-written sequences for reset,
// round-robin rounds, long response waits, timeout, burst drop and reset
// in the middle of a write.
module tb_mem2_arbiter;

    localparam logic [13:0] A0 = 14'h1234;
    localparam logic [13:0] A1 = 14'h02A5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [1:0]  REQ = 2'b11;
    logic [1:0]  WR = 2'b00;
    logic [13:0] ADDR0 = A0;
    logic [13:0] ADDR1 = A1;
    logic [15:0] WDATA0 = 16'h0000;
    logic [15:0] WDATA1 = 16'h0000;
    logic [1:0]  GNT, WR_BEAT, RD_BEAT, DONE, ERR, M_CMD;
    logic [15:0] RDATA, M_WDATA;
    logic [13:0] M_ADDR;
    logic [1:0]  M_RESP = 2'b00;
    logic [15:0] M_RDATA = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;

    mem2_arbiter dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WR(WR),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT(GNT), .WR_BEAT(WR_BEAT), .RD_BEAT(RD_BEAT), .RDATA(RDATA),
        .DONE(DONE), .ERR(ERR), .M_CMD(M_CMD), .M_ADDR(M_ADDR),
        .M_WDATA(M_WDATA), .M_RESP(M_RESP), .M_RDATA(M_RDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [15:0] wd1;
        logic [1:0]  mresp;
        logic [15:0] mrdata;
        logic [1:0]  gnt;
        logic [1:0]  wrb;
        logic [1:0]  rdb;
        logic [15:0] rdata;
        logic [1:0]  done;
        logic [1:0]  err;
        logic [1:0]  mcmd;
        logic [13:0] maddr;
        logic [15:0] mwdata;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #2;
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {GNT, WR_BEAT, RD_BEAT, DONE, ERR, M_CMD, M_ADDR, RDATA, M_WDATA}, 64'd0);
    endtask

    task automatic add(input logic [1:0] req, input logic [1:0] wr, input logic [15:0] wd1,
                       input logic [1:0] mresp, input logic [15:0] mrdata,
                       input logic [1:0] gnt, input logic [1:0] wrb, input logic [1:0] rdb,
                       input logic [15:0] rdata, input logic [1:0] done, input logic [1:0] err,
                       input logic [1:0] mcmd, input logic [13:0] maddr, input logic [15:0] mwdata);
        vec_t v;
        v.req = req; v.wr = wr; v.wd1 = wd1; v.mresp = mresp; v.mrdata = mrdata;
        v.gnt = gnt; v.wrb = wrb; v.rdb = rdb; v.rdata = rdata; v.done = done;
        v.err = err; v.mcmd = mcmd; v.maddr = maddr; v.mwdata = mwdata;
        vq.push_back(v);
    endtask

    // One read transaction starting with an IDLE cycle. nbeats < 8 drops
    // M_RESP after that many beats; never = memory stays silent.
    task automatic do_read(input logic [1:0] req, input logic exp_win, input int delay,
                           input int nbeats, input bit never, input string tag);
        logic [1:0] sel;
        int         bad;
        int         t;
        sel = exp_win ? 2'b10 : 2'b01;
        bad = 0;
        step(); RESET = 1'b1; REQ = req; WR = 2'b00; M_RESP = 2'd0; settle();
        chk({tag, " idle gnt"}, 64'(GNT), 64'd0);
        step(); REQ = 2'b00; settle();
        chk({tag, " gnt"}, 64'(GNT), 64'(sel));
        chk({tag, " rd cmd"}, 64'(M_CMD), 64'd2);
        chk({tag, " rd addr"}, 64'(M_ADDR), 64'(exp_win ? A1 : A0));
        if (never) begin
            t = 0;
            do begin
                step(); settle(); t++;
                if (RD_BEAT != 2'b00 || M_CMD != 2'b00) bad++;
            end while (DONE == 2'b00 && t < 300);
            chk({tag, " timeout cycle"}, 64'(t), 64'd256);
            chk({tag, " timeout done"}, 64'(DONE), 64'(sel));
            chk({tag, " timeout err"}, 64'(ERR), 64'(sel));
            chk({tag, " timeout quiet"}, 64'(bad), 64'd0);
        end else begin
            for (int i = 1; i < delay; i++) begin
                step(); M_RESP = 2'd0; settle();
                if (DONE != 2'b00 || RD_BEAT != 2'b00 || M_CMD != 2'b00 || GNT != 2'b00 || M_ADDR != 14'd0) bad++;
            end
            chk({tag, " wait quiet"}, 64'(bad), 64'd0);
            for (int k = 0; k < 8; k++) begin
                step();
                if (k < nbeats) begin
                    M_RESP = 2'd1; M_RDATA = 16'hB000 + 16'(k);
                end else begin
                    M_RESP = 2'd0; M_RDATA = 16'hFFFF;
                end
                settle();
                if (k < nbeats) begin
                    chk($sformatf("%s beat%0d rd_beat", tag, k), 64'(RD_BEAT), 64'(sel));
                    chk($sformatf("%s beat%0d rdata", tag, k), 64'(RDATA), 64'(16'hB000 + 16'(k)));
                    chk($sformatf("%s beat%0d done", tag, k), 64'(DONE), 64'd0);
                end else begin
                    chk({tag, " gap rd_beat"}, 64'(RD_BEAT), 64'd0);
                    break;
                end
            end
            step(); M_RESP = 2'd0; M_RDATA = 16'h0000; settle();
            chk({tag, " done"}, 64'(DONE), 64'(sel));
            chk({tag, " err"}, 64'(ERR), 64'((nbeats < 8) ? sel : 2'b00));
            chk({tag, " finish rd_beat"}, 64'(RD_BEAT), 64'd0);
        end
    endtask

    // One write transaction; M_RESP is pulsed during beat 2 (must be ignored)
    task automatic do_write(input logic [1:0] req, input logic [1:0] wr, input logic exp_win,
                            input int delay, input string tag);
        logic [1:0] sel;
        int         bad;
        sel = exp_win ? 2'b10 : 2'b01;
        bad = 0;
        step(); REQ = req; WR = wr; M_RESP = 2'd0; settle();
        chk({tag, " idle gnt"}, 64'(GNT), 64'd0);
        for (int k = 0; k < 8; k++) begin
            step(); REQ = 2'b00;
            WDATA0 = 16'h2000 + 16'(k); WDATA1 = 16'h1000 + 16'(k);
            M_RESP = (k == 2) ? 2'd1 : 2'd0;
            settle();
            chk($sformatf("%s beat%0d cmd", tag, k), 64'(M_CMD), 64'd3);
            chk($sformatf("%s beat%0d addr", tag, k), 64'(M_ADDR), 64'(exp_win ? A1 : A0));
            chk($sformatf("%s beat%0d wdata", tag, k), 64'(M_WDATA),
                64'(exp_win ? 16'h1000 + 16'(k) : 16'h2000 + 16'(k)));
            chk($sformatf("%s beat%0d wr_beat", tag, k), 64'(WR_BEAT), 64'(sel));
            chk($sformatf("%s beat%0d gnt", tag, k), 64'(GNT), 64'((k == 0) ? sel : 2'b00));
            chk($sformatf("%s beat%0d done", tag, k), 64'(DONE), 64'd0);
        end
        for (int i = 1; i <= delay; i++) begin
            step(); M_RESP = (i == delay) ? 2'd1 : 2'd0; settle();
            if (M_CMD != 2'b00 || WR_BEAT != 2'b00 || DONE != 2'b00 || M_WDATA != 16'd0 || RD_BEAT != 2'b00) bad++;
        end
        chk({tag, " wait quiet"}, 64'(bad), 64'd0);
        step(); M_RESP = 2'd0; settle();
        chk({tag, " done"}, 64'(DONE), 64'(sel));
        chk({tag, " err"}, 64'(ERR), 64'd0);
    endtask

    initial begin
        int bad;

        // Vector table: port 1 short write, then port 0 short read
        //   req    wr     wd1       mresp  mrdata    gnt    wrb    rdb    rdata     done   err    cmd   maddr  mwdata
        add(2'b10, 2'b10, 16'h0000, 2'd0, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd0, 14'h0, 16'h0000);
        add(2'b00, 2'b10, 16'h1000, 2'd0, 16'h0000, 2'b10, 2'b10, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd3, A1,    16'h1000);
        add(2'b00, 2'b10, 16'h1001, 2'd0, 16'h0000, 2'b00, 2'b10, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd3, A1,    16'h1001);
        add(2'b00, 2'b10, 16'h1002, 2'd1, 16'h5555, 2'b00, 2'b10, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd3, A1,    16'h1002);
        for (int k = 3; k < 8; k++)
            add(2'b00, 2'b10, 16'h1000 + 16'(k), 2'd0, 16'h0000, 2'b00, 2'b10, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd3, A1, 16'h1000 + 16'(k));
        add(2'b00, 2'b10, 16'h0000, 2'd0, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd0, 14'h0, 16'h0000);
        add(2'b00, 2'b10, 16'h0000, 2'd1, 16'h7777, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd0, 14'h0, 16'h0000);
        add(2'b00, 2'b00, 16'h0000, 2'd0, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b10, 2'b00, 2'd0, 14'h0, 16'h0000);
        add(2'b01, 2'b00, 16'h0000, 2'd0, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd0, 14'h0, 16'h0000);
        add(2'b00, 2'b00, 16'h0000, 2'd0, 16'h0000, 2'b01, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd2, A0,    16'h0000);
        for (int k = 0; k < 8; k++)
            add(2'b00, 2'b00, 16'h0000, 2'd1, 16'hA000 + 16'(k), 2'b00, 2'b00, 2'b01, 16'hA000 + 16'(k), 2'b00, 2'b00, 2'd0, 14'h0, 16'h0000);
        add(2'b00, 2'b00, 16'h0000, 2'd3, 16'hFFFF, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b01, 2'b00, 2'd0, 14'h0, 16'h0000);
        add(2'b00, 2'b00, 16'h0000, 2'd0, 16'h0000, 2'b00, 2'b00, 2'b00, 16'h0000, 2'b00, 2'b00, 2'd0, 14'h0, 16'h0000);

        // Reset held low with both requests pending: everything stays 0
        for (int i = 0; i < 2; i++) begin
            step(); settle();
            chk_quiet($sformatf("reset cycle%0d outputs", i));
        end

        // Three read rounds with REQ=11: grant order 0,1,0
        do_read(2'b11, 1'b0, 100, 8, 1'b0, "rr0");
        do_read(2'b11, 1'b1, 100, 8, 1'b0, "rr1");
        do_read(2'b11, 1'b0, 100, 8, 1'b0, "rr2");

        // Table-driven short write + short read
        for (int i = 0; i < vq.size(); i++) begin
            step();
            REQ = vq[i].req; WR = vq[i].wr; WDATA1 = vq[i].wd1;
            M_RESP = vq[i].mresp; M_RDATA = vq[i].mrdata;
            settle();
            chk($sformatf("tbl%0d gnt", i),     64'(GNT),     64'(vq[i].gnt));
            chk($sformatf("tbl%0d wr_beat", i), 64'(WR_BEAT), 64'(vq[i].wrb));
            chk($sformatf("tbl%0d rd_beat", i), 64'(RD_BEAT), 64'(vq[i].rdb));
            chk($sformatf("tbl%0d rdata", i),   64'(RDATA),   64'(vq[i].rdata));
            chk($sformatf("tbl%0d done", i),    64'(DONE),    64'(vq[i].done));
            chk($sformatf("tbl%0d err", i),     64'(ERR),     64'(vq[i].err));
            chk($sformatf("tbl%0d m_cmd", i),   64'(M_CMD),   64'(vq[i].mcmd));
            chk($sformatf("tbl%0d m_addr", i),  64'(M_ADDR),  64'(vq[i].maddr));
            chk($sformatf("tbl%0d m_wdata", i), 64'(M_WDATA), 64'(vq[i].mwdata));
        end

        // Port 1 write with both requesting (pointer is at 1), 100-cycle response
        do_write(2'b11, 2'b10, 1'b1, 100, "wr1");

        // Read with silent memory: abort 256 cycles after the read command
        do_read(2'b01, 1'b0, 0, 0, 1'b1, "tmo");

        // Burst drops after beat 3
        do_read(2'b01, 1'b0, 5, 4, 1'b0, "drop");
        step(); settle();
        chk_quiet("drop idle after finish");

        // Reset during write beat 4 (pointer is 1 before this)
        step(); REQ = 2'b10; WR = 2'b10; settle();
        for (int k = 0; k < 5; k++) begin
            step(); REQ = 2'b00; WDATA1 = 16'h3000 + 16'(k);
            if (k == 4) RESET = 1'b0;
            settle();
            chk($sformatf("rstmid beat%0d cmd", k), 64'(M_CMD), 64'd3);
        end
        step(); RESET = 1'b1; settle();
        chk_quiet("rstmid after reset");
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step(); settle();
            if (DONE != 2'b00 || ERR != 2'b00 || M_CMD != 2'b00 || WR_BEAT != 2'b00) bad++;
        end
        chk("rstmid no done/err", 64'(bad), 64'd0);
        step(); REQ = 2'b11; WR = 2'b00; settle();
        step(); REQ = 2'b00; settle();
        chk("rstmid ptr gnt", 64'(GNT), 64'd1);
        chk("rstmid rd cmd", 64'(M_CMD), 64'd2);
        chk("rstmid rd addr", 64'(M_ADDR), 64'(A0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop if the run ever wedges
    initial begin
        #2000000;
        $display("FAIL watchdog: actual running required finished");
        $fatal(1);
    end

endmodule
